voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 178 +++++++++++++++++
 tb/tb_voice_allocator.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan over N_VOICES voices, then a single commit.
// Optional build macro VOICE_STEAL_EN enables stealing the oldest voice when all are busy.
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 8
`endif

module voice_allocator #(
  parameter int N_VOICES = `N_OSCILLATORS,
  parameter int AGE_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_on,
  input  logic [6:0]            cmd_note,
  input  logic [6:0]            cmd_vel,
  input  logic                  all_off,
  output logic [N_VOICES-1:0]   voice_active,
  output logic [N_VOICES*7-1:0] voice_note,
  output logic [N_VOICES*7-1:0] voice_vel,
  output logic                  upd_valid,
  output logic [4:0]            upd_idx,
  output logic                  upd_hit
);
  localparam int IW = $clog2(N_VOICES);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
  } cmd_t;

  state_t  state, state_nxt;
  cmd_t    cmd;
  logic [IW-1:0] idx;
  logic          match_f, free_f;
  logic [IW-1:0] match_i, free_i;
  logic [N_VOICES-1:0][6:0] note_q, vel_q;
`ifdef VOICE_STEAL_EN
  logic                          best_f;
  logic [IW-1:0]                 best_i;
  logic [AGE_W-1:0]              best_age;
  logic [N_VOICES-1:0][AGE_W-1:0] age;
`endif

  logic          accept, commit, sel_hit;
  logic [IW-1:0] sel_i;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid && cmd_ready && !all_off;
  assign commit     = (state == COMMIT) && !all_off;
  assign voice_note = note_q;
  assign voice_vel  = vel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SCAN;
      SCAN:    if (idx == IW'(N_VOICES-1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (all_off) state_nxt = IDLE;
  end

  // Scan bookkeeping; voice state is frozen during SCAN so one pass is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd     <= '0;
      idx     <= '0;
      match_f <= 1'b0;
      free_f  <= 1'b0;
      match_i <= '0;
      free_i  <= '0;
`ifdef VOICE_STEAL_EN
      best_f   <= 1'b0;
      best_i   <= '0;
      best_age <= '0;
`endif
    end else if (state == IDLE) begin
      idx     <= '0;
      match_f <= 1'b0;
      free_f  <= 1'b0;
`ifdef VOICE_STEAL_EN
      best_f  <= 1'b0;
`endif
      if (accept) cmd <= '{on: cmd_on, note: cmd_note, vel: cmd_vel};
    end else if (state == SCAN) begin
      idx <= idx + 1'b1;
      if (voice_active[idx] && note_q[idx] == cmd.note && !match_f) begin
        match_f <= 1'b1;
        match_i <= idx;
      end
      if (!voice_active[idx] && !free_f) begin
        free_f <= 1'b1;
        free_i <= idx;
      end
`ifdef VOICE_STEAL_EN
      // strict '>' keeps the lowest index on equal ages
      if (voice_active[idx] && (!best_f || age[idx] > best_age)) begin
        best_f   <= 1'b1;
        best_i   <= idx;
        best_age <= age[idx];
      end
`endif
    end
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_i   = '0;
    if (match_f) begin
      sel_hit = 1'b1;
      sel_i   = match_i;
    end else if (cmd.on && free_f) begin
      sel_hit = 1'b1;
      sel_i   = free_i;
    end
`ifdef VOICE_STEAL_EN
    else if (cmd.on && best_f) begin
      sel_hit = 1'b1;
      sel_i   = best_i;
    end
`endif
  end

  assign upd_valid = commit;
  assign upd_hit   = commit && sel_hit;
  assign upd_idx   = (commit && sel_hit) ? 5'(sel_i) : 5'd0;

  for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
    logic             act_q;
    logic [6:0]       nt_q, vl_q;
    logic [AGE_W-1:0] age_q;
    logic             sel;

    assign sel             = sel_hit && (sel_i == IW'(v));
    assign voice_active[v] = act_q;
    assign note_q[v]       = nt_q;
    assign vel_q[v]        = vl_q;
`ifdef VOICE_STEAL_EN
    assign age[v]          = age_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        act_q <= 1'b0;
        nt_q  <= '0;
        vl_q  <= '0;
        age_q <= '0;
      end else if (all_off) begin
        act_q <= 1'b0;
        age_q <= '0;
      end else if (commit && sel_hit) begin
        if (sel) begin
          if (cmd.on) begin
            act_q <= 1'b1;
            nt_q  <= cmd.note;
            vl_q  <= cmd.vel;
            age_q <= '0;
          end else begin
            act_q <= 1'b0;
          end
        end else if (cmd.on && act_q && age_q != '1) begin
          age_q <= age_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (8 voices); expectations follow VOICE_STEAL_EN if defined.
module tb_voice_allocator;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_on = 1'b0;
  logic [6:0]   cmd_note = '0;
  logic [6:0]   cmd_vel = '0;
  logic         all_off = 1'b0;
  logic [N-1:0] voice_active;
  logic [N*7-1:0] voice_note, voice_vel;
  logic         upd_valid;
  logic [4:0]   upd_idx;
  logic         upd_hit;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  voice_allocator #(.N_VOICES(N), .AGE_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_on(cmd_on), .cmd_note(cmd_note), .cmd_vel(cmd_vel), .all_off(all_off),
    .voice_active(voice_active), .voice_note(voice_note), .voice_vel(voice_vel),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_hit(upd_hit)
  );

  // Drives one command from IDLE and samples the update at the expected latency.
  task automatic send(input logic on, input logic [6:0] n, input logic [6:0] v,
                      output logic early, output logic valid,
                      output logic [4:0] idx, output logic hit);
    @(negedge clk);
    cmd_on = on; cmd_note = n; cmd_vel = v; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (N-1) @(posedge clk);
    #1 early = upd_valid;
    @(posedge clk);
    #1 valid = upd_valid; idx = upd_idx; hit = upd_hit;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (voice_active !== '0) begin bad++; $display("FAIL reset_active got=%0h exp=0", voice_active); end
    total++; if (voice_note !== '0 || voice_vel !== '0) begin bad++; $display("FAIL reset_note_vel got=%0h/%0h exp=0", voice_note, voice_vel); end
    total++; if ({upd_valid, upd_idx, upd_hit} !== 7'd0) begin bad++; $display("FAIL reset_upd got=%0b exp=0", {upd_valid, upd_idx, upd_hit}); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_note_on();
    logic e, val, h; logic [4:0] i;
    send(1'b1, 7'd60, 7'd100, e, val, i, h);
    total++; if (e !== 1'b0) begin bad++; $display("FAIL on_early_valid got=%0b exp=0", e); end
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b1}) begin bad++; $display("FAIL on_upd got=%0b/%0d/%0b exp=1/0/1", val, i, h); end
    total++; if (voice_active !== 8'h01 || voice_note[6:0] !== 7'd60 || voice_vel[6:0] !== 7'd100)
      begin bad++; $display("FAIL on_voice0 got=%0h/%0d/%0d exp=1/60/100", voice_active, voice_note[6:0], voice_vel[6:0]); end
    total++; if (cmd_ready !== 1'b1 || upd_valid !== 1'b0) begin bad++; $display("FAIL on_after got=%0b/%0b exp=1/0", cmd_ready, upd_valid); end
  endtask

  task automatic test_retrigger();
    logic e, val, h; logic [4:0] i;
    send(1'b1, 7'd60, 7'd20, e, val, i, h);
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b1}) begin bad++; $display("FAIL retrig_upd got=%0b/%0d/%0b exp=1/0/1", val, i, h); end
    total++; if (voice_active !== 8'h01 || voice_vel[6:0] !== 7'd20) begin bad++; $display("FAIL retrig_voice got=%0h/%0d exp=1/20", voice_active, voice_vel[6:0]); end
  endtask

  task automatic test_note_off();
    logic e, val, h; logic [4:0] i;
    send(1'b0, 7'd99, 7'd0, e, val, i, h);
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b0}) begin bad++; $display("FAIL off_miss_upd got=%0b/%0d/%0b exp=1/0/0", val, i, h); end
    total++; if (voice_active !== 8'h01) begin bad++; $display("FAIL off_miss_active got=%0h exp=1", voice_active); end
    send(1'b0, 7'd60, 7'd0, e, val, i, h);
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b1}) begin bad++; $display("FAIL off_hit_upd got=%0b/%0d/%0b exp=1/0/1", val, i, h); end
    total++; if (voice_active !== 8'h00 || voice_note[6:0] !== 7'd60) begin bad++; $display("FAIL off_hit_voice got=%0h/%0d exp=0/60", voice_active, voice_note[6:0]); end
  endtask

  task automatic test_fill_steal();
    logic e, val, h; logic [4:0] i;
    logic [N*7-1:0] exp_notes;
    do_reset();
    for (int k = 0; k < N; k++) begin
      send(1'b1, 7'(60 + k), 7'(10 + k), e, val, i, h);
      exp_notes[k*7 +: 7] = 7'(60 + k);
      total++; if (i !== 5'(k) || h !== 1'b1) begin bad++; $display("FAIL fill_%0d got=%0d/%0b exp=%0d/1", k, i, h, k); end
    end
    total++; if (voice_active !== 8'hFF) begin bad++; $display("FAIL fill_active got=%0h exp=ff", voice_active); end
    send(1'b1, 7'd70, 7'd5, e, val, i, h);
`ifdef VOICE_STEAL_EN
    exp_notes[6:0] = 7'd70;
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b1}) begin bad++; $display("FAIL steal_upd got=%0b/%0d/%0b exp=1/0/1", val, i, h); end
    total++; if (voice_note !== exp_notes || voice_active !== 8'hFF) begin bad++; $display("FAIL steal_notes got=%0h exp=%0h", voice_note, exp_notes); end
    send(1'b1, 7'd71, 7'd5, e, val, i, h);
    exp_notes[13:7] = 7'd71;
    total++; if (i !== 5'd1 || h !== 1'b1) begin bad++; $display("FAIL steal2_upd got=%0d/%0b exp=1/1", i, h); end
    total++; if (voice_note !== exp_notes) begin bad++; $display("FAIL steal2_notes got=%0h exp=%0h", voice_note, exp_notes); end
`else
    total++; if ({val, i, h} !== {1'b1, 5'd0, 1'b0}) begin bad++; $display("FAIL drop_upd got=%0b/%0d/%0b exp=1/0/0", val, i, h); end
    total++; if (voice_note !== exp_notes || voice_active !== 8'hFF) begin bad++; $display("FAIL drop_notes got=%0h exp=%0h", voice_note, exp_notes); end
`endif
    send(1'b0, 7'd65, 7'd0, e, val, i, h);
    total++; if (i !== 5'd5 || h !== 1'b1 || voice_active !== 8'hDF) begin bad++; $display("FAIL reuse_off got=%0d/%0b/%0h exp=5/1/df", i, h, voice_active); end
    send(1'b1, 7'd81, 7'd9, e, val, i, h);
    total++; if (i !== 5'd5 || h !== 1'b1 || voice_note[41:35] !== 7'd81) begin bad++; $display("FAIL reuse_on got=%0d/%0b/%0d exp=5/1/81", i, h, voice_note[41:35]); end
  endtask

  task automatic test_all_off();
    logic e, val, h; logic [4:0] i;
    logic seen;
    do_reset();
    for (int k = 0; k < 3; k++) send(1'b1, 7'(60 + k), 7'd50, e, val, i, h);
    total++; if (voice_active !== 8'h07) begin bad++; $display("FAIL alloff_pre got=%0h exp=07", voice_active); end
    @(negedge clk);
    cmd_on = 1'b1; cmd_note = 7'd90; cmd_vel = 7'd1; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    all_off = 1'b1;
    @(posedge clk); #1;
    total++; if (voice_active !== 8'h00 || cmd_ready !== 1'b1 || upd_valid !== 1'b0)
      begin bad++; $display("FAIL alloff_mid got=%0h/%0b/%0b exp=0/1/0", voice_active, cmd_ready, upd_valid); end
    @(negedge clk); all_off = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin @(posedge clk); #1 if (upd_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL alloff_no_upd got=%0b exp=0", seen); end
    // all_off coincident with a would-be accept blocks it
    @(negedge clk); cmd_valid = 1'b1; all_off = 1'b1;
    @(posedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL alloff_block_ready got=%0b exp=1", cmd_ready); end
    @(negedge clk); cmd_valid = 1'b0; all_off = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin @(posedge clk); #1 if (upd_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL alloff_block_upd got=%0b exp=0", seen); end
  endtask

  task automatic test_rst_mid_scan();
    logic e, val, h; logic [4:0] i;
    logic seen;
    send(1'b1, 7'd72, 7'd33, e, val, i, h);
    total++; if (voice_active !== 8'h01 || voice_note[6:0] !== 7'd72) begin bad++; $display("FAIL rst_pre got=%0h/%0d exp=1/72", voice_active, voice_note[6:0]); end
    @(negedge clk);
    cmd_on = 1'b1; cmd_note = 7'd73; cmd_vel = 7'd2; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (voice_active !== '0 || voice_note !== '0 || voice_vel !== '0 || cmd_ready !== 1'b1 || {upd_valid, upd_idx, upd_hit} !== 7'd0)
      begin bad++; $display("FAIL rst_async got=%0h/%0h/%0b/%0b exp=0/0/1/0", voice_active, voice_note, cmd_ready, upd_valid); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < N + 4; k++) begin @(posedge clk); #1 if (upd_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0 || voice_active !== '0) begin bad++; $display("FAIL rst_no_upd got=%0b/%0h exp=0/0", seen, voice_active); end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_retrigger();
    test_note_off();
    test_fill_steal();
    test_all_off();
    test_rst_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
